muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have a parameter DATA_WIDTH, default 32, setting the operand and result width (any even value >= 8).
REQ-002 The block SHALL have a parameter SEL_WIDTH, default 3, setting the operation-select width (RV32M funct3 encoding).
REQ-003 Port i_clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port i_rst, input, 1 bit, SHALL be the reset; it is synchronous and active-high.
REQ-005 Port i_valid, input, 1 bit, SHALL indicate that the request operands and op are valid.
REQ-006 Port o_ready, output, 1 bit, SHALL indicate that a request can be accepted.
REQ-007 Port i_src_a, input, DATA_WIDTH bits, SHALL carry the multiplicand or dividend.
REQ-008 Port i_src_b, input, DATA_WIDTH bits, SHALL carry the multiplier or divisor.
REQ-009 Port i_sel, input, SEL_WIDTH bits, SHALL select the operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 Port o_valid, output, 1 bit, SHALL indicate that o_data and o_zero hold a completed result.
REQ-011 Port i_ready, input, 1 bit, SHALL indicate that the consumer accepts the result.
REQ-012 Port o_data, output, DATA_WIDTH bits, SHALL carry the result.
REQ-013 Port o_zero, output, 1 bit, SHALL be high when o_data equals zero.

Function
REQ-014 A request SHALL be accepted on a rising edge where i_valid and o_ready are both high; operands and op SHALL be latched on that edge.
REQ-015 The state machine SHALL have four states: IDLE, MUL, DIV and DONE; o_ready SHALL be high only in IDLE.
REQ-016 On accept, the next state SHALL be: MUL for ops 000-011; DONE for a special divide case (REQ-021, REQ-022); DIV otherwise.
REQ-017 In the MUL state, the block SHALL form the 2*DATA_WIDTH product with the operand signedness of the op (MULHSU: a signed, b unsigned), register the selected half (low half for MUL, high half otherwise), and enter DONE after exactly one cycle.
REQ-018 In the DIV state, the block SHALL run restoring division on operand magnitudes at one quotient bit per cycle for exactly DATA_WIDTH cycles, then enter DONE.
REQ-019 A signed divide SHALL negate the quotient when the operand signs differ, and SHALL give the remainder the sign of the dividend.
REQ-020 Latency SHALL be: accept edge k -> o_valid high after edge k+2 for multiply, after edge k+DATA_WIDTH+1 for divide, and after edge k+1 for special cases.
REQ-021 Divide by zero SHALL give a quotient of all ones (DIV and DIVU) and a remainder equal to i_src_a (REM and REMU).
REQ-022 Signed overflow (a = most-negative value, b = -1) SHALL give quotient = a for DIV and 0 for REM.
REQ-023 In DONE, o_valid SHALL be high; o_data and o_zero SHALL remain stable until the edge where i_ready is high, on which the state SHALL return to IDLE.
REQ-024 A new request SHALL be accepted no earlier than the edge after the result handshake; requests SHALL never overlap.
REQ-025 Changes on i_src_a, i_src_b and i_sel after the accept edge SHALL NOT affect the result in flight.

Reset
REQ-026 While i_rst is high at a rising edge, the state SHALL become IDLE, o_valid SHALL become 0, o_data SHALL become 0, o_zero SHALL become 1, and o_ready SHALL be 1 on the following cycle.
REQ-027 Reset asserted in MUL, DIV or DONE SHALL abandon the operation with no result presented; i_valid SHALL be ignored while i_rst is high.

Structure
REQ-028 The op encodings and the state enum SHALL be defined in the shared package riscv_pkg, alongside the ALU select constants.
REQ-029 The restoring-divide datapath (remainder, quotient and counter registers) SHALL be a sub-module named muldiv_divider; the multiply path and FSM SHALL stay in muldiv_unit.

Verification
REQ-030 The bench SHALL cover MULH with a = 0x80000000, b = 0x80000000 -> o_data = 0x40000000, o_valid 2 cycles after accept.
REQ-031 The bench SHALL cover DIV with a = -7, b = 2 -> o_data = 0xFFFFFFFD; REM with the same operands -> o_data = 0xFFFFFFFF; o_valid 33 cycles after accept.
REQ-032 The bench SHALL cover DIVU with a = 5, b = 0 -> o_data = 0xFFFFFFFF after 1 cycle; REMU with the same operands -> o_data = 5 and o_zero = 0.
REQ-033 The bench SHALL cover DIV with a = 0x80000000, b = 0xFFFFFFFF -> o_data = 0x80000000; REM with the same operands -> o_data = 0 and o_zero = 1.
REQ-034 The bench SHALL cover holding i_ready low for 5 cycles in DONE -> o_valid and o_data stable throughout, o_ready low until 1 cycle after the handshake.
REQ-035 The bench SHALL cover i_rst pulsed 10 cycles into a DIVU -> o_valid = 0 and o_ready = 1 next cycle, and a following MUL 3 * 4 -> o_data = 12.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: ALU selects, M-extension op encodings and
// the multiply/divide unit state machine.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // RV32M funct3 encoding.
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_mul_op(input muldiv_op_e op);
    return !op[2];
  endfunction

  // DIV and REM are the signed divides; bit 0 marks the unsigned forms.
  function automatic logic is_signed_div(input muldiv_op_e op);
    return op[2] && !op[0];
  endfunction

  function automatic logic is_rem_op(input muldiv_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step,
// DATA_WIDTH steps per division.
module muldiv_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_step,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder,
  output logic                  o_last
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [W-1:0]     rem_q;
  logic [W-1:0]     quo_q;
  logic [W-1:0]     dvsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W:0]       partial;
  logic [W:0]       trial;

  // The dividend shifts out of quo_q into the partial remainder as quotient
  // bits shift in; a borrow out of the trial subtract means restore.
  assign partial = {rem_q, quo_q[W-1]};
  assign trial   = partial - {1'b0, dvsr_q};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (i_start) begin
      rem_q  <= '0;
      quo_q  <= i_dividend;
      dvsr_q <= i_divisor;
      cnt_q  <= '0;
    end else if (i_step) begin
      if (!trial[W]) begin
        rem_q <= trial[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b1};
      end else begin
        rem_q <= partial[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b0};
      end
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_quotient  = quo_q;
  assign o_remainder = rem_q;
  assign o_last      = i_step && (cnt_q == CNT_W'(W - 1));

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: single-cycle multiply, iterative restoring
// divide, valid/ready request and result handshakes.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_src_a,
  input  logic [DATA_WIDTH-1:0] i_src_b,
  input  logic [SEL_WIDTH-1:0]  i_sel,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_zero
);
  localparam int           W        = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  md_state_e  state_q, state_d;
  muldiv_op_e op_in, op_q;

  logic           accept;
  logic           is_mul_in, signed_in, div_by_zero, div_ovf, special_in;
  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag, special_res;
  logic [W-1:0]   a_q, b_q, res_q;
  logic           use_div_q, q_neg_q, r_neg_q;
  logic           a_sext, b_sext;
  logic [2*W-1:0] a_ext, b_ext, product;
  logic [W-1:0]   div_quo, div_rem, div_res, final_res;
  logic           div_step, div_last;
  logic           valid_q;

  // Request decode, evaluated on the live inputs at the accept edge.
  assign op_in       = muldiv_op_e'(i_sel[2:0]);
  assign accept      = i_valid && o_ready && !i_rst;
  assign is_mul_in   = is_mul_op(op_in);
  assign signed_in   = is_signed_div(op_in);
  assign div_by_zero = (i_src_b == '0);
  assign div_ovf     = signed_in && (i_src_a == MOST_NEG) && (i_src_b == '1);
  assign special_in  = !is_mul_in && (div_by_zero || div_ovf);
  assign special_res = div_by_zero ? (is_rem_op(op_in) ? i_src_a : '1)
                                   : (is_rem_op(op_in) ? '0 : i_src_a);

  assign a_neg = signed_in && i_src_a[W-1];
  assign b_neg = signed_in && i_src_b[W-1];
  assign a_mag = a_neg ? -i_src_a : i_src_a;
  assign b_mag = b_neg ? -i_src_b : i_src_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul_in)       state_d = ST_MUL;
          else if (special_in) state_d = ST_DONE;
          else                 state_d = ST_DIV;
        end
      end
      ST_MUL:  state_d = ST_DONE;
      ST_DIV:  if (div_last) state_d = ST_DONE;
      ST_DONE: if (valid_q && i_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready  = (state_q == ST_IDLE);
    div_step = (state_q == ST_DIV);
  end

  // NOTE: operand and intermediate registers carry no reset; they are only
  // read in states reached through an accept, which always reloads them.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_q      <= op_in;
      a_q       <= i_src_a;
      b_q       <= i_src_b;
      q_neg_q   <= a_neg ^ b_neg;
      r_neg_q   <= a_neg;
      use_div_q <= !is_mul_in && !special_in;
    end
    if (accept && special_in) begin
      res_q <= special_res;
    end else if (state_q == ST_MUL) begin
      res_q <= (op_q == MD_MUL) ? product[W-1:0] : product[2*W-1:W];
    end
  end

  // MULH treats both operands as signed, MULHSU only the multiplicand.
  assign a_sext  = ((op_q == MD_MULH) || (op_q == MD_MULHSU)) && a_q[W-1];
  assign b_sext  = (op_q == MD_MULH) && b_q[W-1];
  assign a_ext   = {{W{a_sext}}, a_q};
  assign b_ext   = {{W{b_sext}}, b_q};
  assign product = a_ext * b_ext;

  muldiv_divider #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_divider (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (accept),
    .i_step      (div_step),
    .i_dividend  (a_mag),
    .i_divisor   (b_mag),
    .o_quotient  (div_quo),
    .o_remainder (div_rem),
    .o_last      (div_last)
  );

  // Sign fix-up: quotient negated on differing signs, remainder follows dividend.
  assign div_res   = is_rem_op(op_q) ? (r_neg_q ? -div_rem : div_rem)
                                     : (q_neg_q ? -div_quo : div_quo);
  assign final_res = use_div_q ? div_res : res_q;

  // The result is captured on the first DONE cycle and then held until taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      o_data  <= '0;
      o_zero  <= 1'b1;
    end else if (state_q == ST_DONE) begin
      if (!valid_q) begin
        valid_q <= 1'b1;
        o_data  <= final_res;
        o_zero  <= (final_res == '0);
      end else if (i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_valid = valid_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;
  localparam int W = 32;

  localparam logic [2:0] SEL_MUL    = 3'b000;
  localparam logic [2:0] SEL_MULH   = 3'b001;
  localparam logic [2:0] SEL_MULHSU = 3'b010;
  localparam logic [2:0] SEL_MULHU  = 3'b011;
  localparam logic [2:0] SEL_DIV    = 3'b100;
  localparam logic [2:0] SEL_DIVU   = 3'b101;
  localparam logic [2:0] SEL_REM    = 3'b110;
  localparam logic [2:0] SEL_REMU   = 3'b111;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_src_a;
  logic [W-1:0] i_src_b;
  logic [2:0]   i_sel;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_data;
  logic         o_zero;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  muldiv_unit #(
    .DATA_WIDTH (W),
    .SEL_WIDTH  (3)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_src_a (i_src_a),
    .i_src_b (i_src_b),
    .i_sel   (i_sel),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_zero  (o_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one request, scramble the inputs after accept, wait for the result,
  // optionally stall the consumer, then complete the handshake.
  task automatic run_op(input string tag, input logic [2:0] sel,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input logic expz,
                        input int exp_lat, input int hold);
    int lat;
    check({tag, "_ready_before"}, 64'(o_ready), 64'(1'b1));
    i_sel   = sel;
    i_src_a = a;
    i_src_b = b;
    i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    i_src_a = $urandom;
    i_src_b = $urandom;
    i_sel   = 3'($urandom);
    check({tag, "_ready_busy"}, 64'(o_ready), 64'(1'b0));
    lat = 0;
    while (!o_valid && lat < 200) begin
      cycle();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, 64'(o_data), 64'(exp));
    check({tag, "_zero"}, 64'(o_zero), 64'(expz));
    for (int i = 0; i < hold; i++) begin
      cycle();
      check({tag, "_hold_valid"}, 64'(o_valid), 64'(1'b1));
      check({tag, "_hold_data"}, 64'(o_data), 64'(exp));
      check({tag, "_hold_ready"}, 64'(o_ready), 64'(1'b0));
    end
    i_ready = 1'b1;
    cycle();
    i_ready = 1'b0;
    check({tag, "_valid_after"}, 64'(o_valid), 64'(1'b0));
    check({tag, "_ready_after"}, 64'(o_ready), 64'(1'b1));
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_src_a = '0;
    i_src_b = '0;
    i_sel   = '0;
    cycle();
    cycle();
    check("rst_valid", 64'(o_valid), 64'(1'b0));
    check("rst_data", 64'(o_data), 64'(0));
    check("rst_zero", 64'(o_zero), 64'(1'b1));
    check("rst_ready", 64'(o_ready), 64'(1'b1));
    i_rst = 1'b0;
    cycle();

    // Multiplies: two cycles from accept to o_valid.
    run_op("mulh_minmin",   SEL_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 2, 0);
    run_op("mul_3x4",       SEL_MUL,    32'd3,         32'd4,         32'd12,        1'b0, 2, 0);
    run_op("mulhu_ones",    SEL_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 2, 0);
    run_op("mulhsu_ones",   SEL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2, 0);
    run_op("mul_wrap_zero", SEL_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 2, 0);

    // Iterative divides: DATA_WIDTH + 1 cycles.
    run_op("div_m7_2",      SEL_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33, 0);
    run_op("rem_m7_2",      SEL_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 33, 0);
    run_op("div_7_m2",      SEL_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33, 0);
    run_op("rem_7_m2",      SEL_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0, 33, 0);
    run_op("divu_100_7",    SEL_DIVU, 32'd100,       32'd7,         32'd14,        1'b0, 33, 0);
    run_op("remu_100_7",    SEL_REMU, 32'd100,       32'd7,         32'd2,         1'b0, 33, 0);
    run_op("divu_min_ones", SEL_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, 33, 0);

    // Special cases resolve in one cycle.
    run_op("divu_by_zero",  SEL_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1, 0);
    run_op("remu_by_zero",  SEL_REMU, 32'd5,         32'd0,         32'd5,         1'b0, 1, 0);
    run_op("div_by_zero",   SEL_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1, 0);
    run_op("rem_by_zero",   SEL_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0, 1, 0);
    run_op("div_overflow",  SEL_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 0);
    run_op("rem_overflow",  SEL_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, 1, 0);

    // Consumer stall: result held for five cycles before the handshake.
    run_op("mul_stall",     SEL_MUL,  32'd6,         32'd7,         32'd42,        1'b0, 2, 5);

    // Reset mid-divide abandons the operation; i_valid is ignored under reset.
    i_sel   = SEL_DIVU;
    i_src_a = 32'd100;
    i_src_b = 32'd7;
    i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    repeat (10) cycle();
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_sel   = SEL_MUL;
    cycle();
    i_rst   = 1'b0;
    i_valid = 1'b0;
    check("midrst_valid", 64'(o_valid), 64'(1'b0));
    check("midrst_ready", 64'(o_ready), 64'(1'b1));
    repeat (40) cycle();
    check("midrst_no_result", 64'(o_valid), 64'(1'b0));
    check("midrst_still_idle", 64'(o_ready), 64'(1'b1));
    run_op("mul_after_rst", SEL_MUL,  32'd3,         32'd4,         32'd12,        1'b0, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
